// File: rtl/control_unit_if.sv
// control_unit_if: bundles the sequencer inputs (IR, CON, stop) and every
// datapath control output between control_unit (master) and datapath (slave).
//   IR     instruction register contents, opcode in IR[31:27]
//   CON    branch-condition flip-flop output
//   stop   halt request, honoured only at the T0 boundary
//   Run    1 while sequencing, 0 in HALT
//   ALUop  ALU operation select
//   others one-cycle datapath strobes
interface control_unit_if #(parameter int OPW = 5);
    logic [31:0] IR;
    logic CON, stop, Run;
    logic [OPW-1:0] ALUop;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin;
    logic RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin;
    modport master (
        input IR, CON, stop,
        output Run, ALUop, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin,
        output RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout,
        output Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin
    );
    modport slave (
        output IR, CON, stop,
        input Run, ALUop, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin,
        input RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout,
        input Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore hardwired sequencer for the Mini SRC CPU.
//   clock  rising-edge clock
//   clear  asynchronous active-low reset (state T0, strobes 0, Run=1)
//   bus    control_unit_if master: IR/CON/stop in, Run/ALUop/strobes out
// Fetch T0-T2, per-opcode execute T3-T7, back to T0; HALT on halt opcode or stop.
module control_unit #(
    parameter int OPW = 5,
    parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
    input logic clock,
    input logic clear,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} stateT;
    typedef struct packed {
        logic Run;
        logic [OPW-1:0] ALUop;
        logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite, IRin;
        logic RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout;
        logic Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin;
    } outT;

    // state names the step whose strobes are loaded on the next edge, so the
    // registered outputs always show the strobes of the step just entered
    stateT state, nxState;
    outT outs, nx;
    logic [OPW-1:0] op;
    logic isAlu, isImm, isMulDiv, isNeg, isLd, isLdi, isSt, isBr, isJr, isMfhi, isMflo, isHalt;
    logic unusedIrBits;

    assign op = bus.IR[31:32-OPW];
    assign unusedIrBits = ^bus.IR[31-OPW:0];
    assign isAlu = op >= 5'd3 && op <= 5'd11;
    assign isImm = op >= 5'd12 && op <= 5'd14;
    assign isMulDiv = op == 5'd15 || op == 5'd16;
    assign isNeg = op == 5'd17 || op == 5'd18;
    assign isLd = op == 5'd0;
    assign isLdi = op == 5'd1;
    assign isSt = op == 5'd2;
    assign isBr = op == 5'd19;
    assign isJr = op == 5'd20;
    assign isMfhi = op == 5'd24;
    assign isMflo = op == 5'd25;
    assign isHalt = op == 5'd27;

    always_comb begin
        nx = '0;
        nx.Run = 1'b1;
        nxState = T0;
        if (state inside {T3, T4, T5, T6, T7})
            nx.ALUop = (isAlu || isImm || isMulDiv || isNeg) ? op : ADD_OP;
        case (state)
            T0: begin
                if (stop_t0()) begin
                    nx.Run = 1'b0;
                    nxState = HALT;
                end else begin
                    {nx.PCout, nx.MARin, nx.IncPC} = 3'b111;
                    nxState = T1;
                end
            end
            T1: begin
                {nx.MDRread, nx.MDRin} = 2'b11;
                nxState = T2;
            end
            T2: begin
                {nx.MDRout, nx.IRin} = 2'b11;
                nxState = T3;
            end
            T3: begin
                nxState = T4;
                if (isAlu || isImm) {nx.Grb, nx.Rout, nx.RYin} = 3'b111;
                else if (isMulDiv) {nx.Gra, nx.Rout, nx.RYin} = 3'b111;
                else if (isNeg) {nx.Grb, nx.Rout, nx.RZinLo} = 3'b111;
                else if (isLd || isLdi || isSt) {nx.Grb, nx.BAout, nx.RYin} = 3'b111;
                else if (isBr) {nx.Gra, nx.Rout, nx.CONin} = 3'b111;
                else begin
                    nxState = isHalt ? HALT : T0;
                    if (isJr) {nx.Gra, nx.Rout, nx.PCin} = 3'b111;
                    if (isMfhi) {nx.HIout, nx.Gra, nx.Rin} = 3'b111;
                    if (isMflo) {nx.LOout, nx.Gra, nx.Rin} = 3'b111;
                end
            end
            T4: begin
                nxState = T5;
                if (isAlu) {nx.Grc, nx.Rout, nx.RZinLo} = 3'b111;
                else if (isImm || isLd || isLdi || isSt) {nx.RCout, nx.RZinLo} = 2'b11;
                else if (isMulDiv) {nx.Grb, nx.Rout, nx.RZinLo, nx.RZinHi} = 4'b1111;
                else if (isBr) {nx.PCout, nx.RYin} = 2'b11;
                else begin
                    nxState = T0;
                    if (isNeg) {nx.RZoutLo, nx.Gra, nx.Rin} = 3'b111;
                end
            end
            T5: begin
                nxState = T6;
                if (isMulDiv) {nx.RZoutLo, nx.LOin} = 2'b11;
                else if (isLd || isSt) {nx.RZoutLo, nx.MARin} = 2'b11;
                else if (isBr) {nx.RCout, nx.RZinLo} = 2'b11;
                else begin
                    nxState = T0;
                    if (isAlu || isImm || isLdi) {nx.RZoutLo, nx.Gra, nx.Rin} = 3'b111;
                end
            end
            T6: begin
                nxState = (isLd || isSt) ? T7 : T0;
                if (isMulDiv) {nx.RZoutHi, nx.HIin} = 2'b11;
                if (isLd) {nx.MDRread, nx.MDRin} = 2'b11;
                if (isSt) {nx.Gra, nx.Rout, nx.MDRin} = 3'b111;
                // branch target only taken when the condition flop is set
                if (isBr && bus.CON) {nx.RZoutLo, nx.PCin} = 2'b11;
            end
            T7: begin
                if (isLd) {nx.MDRout, nx.Gra, nx.Rin} = 3'b111;
                if (isSt) nx.RAMwrite = 1'b1;
            end
            HALT: begin
                nx.Run = 1'b0;
                nxState = HALT;
            end
            default: ;
        endcase
    end

    function automatic logic stop_t0();
        return bus.stop;
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= T0;
            outs <= '0;
            outs.Run <= 1'b1;
        end else begin
            state <= nxState;
            outs <= nx;
        end
    end

    assign bus.Run = outs.Run;
    assign bus.ALUop = outs.ALUop;
    assign bus.PCout = outs.PCout;
    assign bus.PCin = outs.PCin;
    assign bus.IncPC = outs.IncPC;
    assign bus.MARin = outs.MARin;
    assign bus.MDRin = outs.MDRin;
    assign bus.MDRout = outs.MDRout;
    assign bus.MDRread = outs.MDRread;
    assign bus.RAMwrite = outs.RAMwrite;
    assign bus.IRin = outs.IRin;
    assign bus.RYin = outs.RYin;
    assign bus.RZinLo = outs.RZinLo;
    assign bus.RZinHi = outs.RZinHi;
    assign bus.RZoutLo = outs.RZoutLo;
    assign bus.RZoutHi = outs.RZoutHi;
    assign bus.HIin = outs.HIin;
    assign bus.LOin = outs.LOin;
    assign bus.HIout = outs.HIout;
    assign bus.LOout = outs.LOout;
    assign bus.Gra = outs.Gra;
    assign bus.Grb = outs.Grb;
    assign bus.Grc = outs.Grc;
    assign bus.Rin = outs.Rin;
    assign bus.Rout = outs.Rout;
    assign bus.BAout = outs.BAout;
    assign bus.RCout = outs.RCout;
    assign bus.CONin = outs.CONin;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector self-checking bench for control_unit.
module tb_control_unit;
    localparam logic [25:0] PCO = 26'd1 << 25, PCI = 26'd1 << 24, INC = 26'd1 << 23, MARI = 26'd1 << 22;
    localparam logic [25:0] MDRI = 26'd1 << 21, MDRO = 26'd1 << 20, MDRR = 26'd1 << 19, RAMW = 26'd1 << 18;
    localparam logic [25:0] IRI = 26'd1 << 17, RYI = 26'd1 << 16, RZLI = 26'd1 << 15, RZHI = 26'd1 << 14;
    localparam logic [25:0] RZLO = 26'd1 << 13, RZHO = 26'd1 << 12, HII = 26'd1 << 11, LOI = 26'd1 << 10;
    localparam logic [25:0] HIO = 26'd1 << 9, LOO = 26'd1 << 8, GRA = 26'd1 << 7, GRB = 26'd1 << 6;
    localparam logic [25:0] GRC = 26'd1 << 5, RIN = 26'd1 << 4, ROUT = 26'd1 << 3, BAO = 26'd1 << 2;
    localparam logic [25:0] RCO = 26'd1 << 1, CONI = 26'd1 << 0;
    localparam logic [25:0] DRIVERS = PCO | MDRO | RZLO | RZHO | HIO | LOO | ROUT | BAO | RCO;
    localparam logic [4:0] DC = 5'h1F;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int total = 0;
    int bad = 0;
    logic [25:0] sv;

    control_unit_if bus ();
    control_unit dut (.clock(clock), .clear(clear), .bus(bus.master));

    always #5 clock = ~clock;

    assign sv = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.MDRread,
                 bus.RAMwrite, bus.IRin, bus.RYin, bus.RZinLo, bus.RZinHi, bus.RZoutLo, bus.RZoutHi,
                 bus.HIin, bus.LOin, bus.HIout, bus.LOout, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                 bus.Rout, bus.BAout, bus.RCout, bus.CONin};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [25:0] expS, input logic [4:0] expA, input logic expR);
        check({tag, " strobes"}, 32'(sv), 32'(expS));
        check({tag, " Run"}, 32'(bus.Run), 32'(expR));
        if (expA != DC) check({tag, " ALUop"}, 32'(bus.ALUop), 32'(expA));
        check({tag, " busOneHot"}, 32'($countones(sv & DRIVERS) <= 1), 32'd1);
    endtask

    task automatic step(input string tag, input logic [25:0] expS, input logic [4:0] expA, input logic expR);
        @(negedge clock);
        look(tag, expS, expA, expR);
    endtask

    task automatic fetch(input string name);
        step({name, " T0"}, PCO | MARI | INC, 5'd0, 1'b1);
        step({name, " T1"}, MDRR | MDRI, 5'd0, 1'b1);
        step({name, " T2"}, MDRO | IRI, 5'd0, 1'b1);
    endtask

    task automatic pulseClear(input string tag);
        clear = 1'b0;
        #1;
        look(tag, 26'd0, 5'd0, 1'b1);
        #2;
        clear = 1'b1;
    endtask

    initial begin
        bus.IR = 32'h19A28000;
        bus.CON = 1'b0;
        bus.stop = 1'b0;
        step("reset", 26'd0, 5'd0, 1'b1);
        step("reset hold", 26'd0, 5'd0, 1'b1);
        clear = 1'b1;
        fetch("add");
        step("add T3", GRB | ROUT | RYI, 5'd3, 1'b1);
        step("add T4", GRC | ROUT | RZLI, 5'd3, 1'b1);
        step("add T5", RZLO | GRA | RIN, 5'd3, 1'b1);
        bus.IR = 32'h00900054;
        fetch("ld");
        step("ld T3", GRB | BAO | RYI, 5'd3, 1'b1);
        step("ld T4", RCO | RZLI, 5'd3, 1'b1);
        step("ld T5", RZLO | MARI, 5'd3, 1'b1);
        step("ld T6", MDRR | MDRI, DC, 1'b1);
        step("ld T7", MDRO | GRA | RIN, DC, 1'b1);
        bus.IR = 32'h98800000;
        bus.CON = 1'b1;
        fetch("br1");
        step("br1 T3", GRA | ROUT | CONI, DC, 1'b1);
        step("br1 T4", PCO | RYI, 5'd3, 1'b1);
        step("br1 T5", RCO | RZLI, 5'd3, 1'b1);
        step("br1 T6", RZLO | PCI, DC, 1'b1);
        bus.CON = 1'b0;
        fetch("br0");
        step("br0 T3", GRA | ROUT | CONI, DC, 1'b1);
        step("br0 T4", PCO | RYI, 5'd3, 1'b1);
        step("br0 T5", RCO | RZLI, 5'd3, 1'b1);
        step("br0 T6", 26'd0, DC, 1'b1);
        bus.IR = 32'h81880000;
        fetch("mul");
        step("mul T3", GRA | ROUT | RYI, 5'd16, 1'b1);
        step("mul T4", GRB | ROUT | RZLI | RZHI, 5'd16, 1'b1);
        step("mul T5", RZLO | LOI, 5'd16, 1'b1);
        step("mul T6", RZHO | HII, 5'd16, 1'b1);
        bus.IR = 32'h88000000;
        fetch("neg");
        step("neg T3", GRB | ROUT | RZLI, 5'd17, 1'b1);
        step("neg T4", RZLO | GRA | RIN, 5'd17, 1'b1);
        bus.IR = 32'hA0000000;
        fetch("jr");
        step("jr T3", GRA | ROUT | PCI, DC, 1'b1);
        bus.IR = 32'hC0000000;
        fetch("mfhi");
        step("mfhi T3", HIO | GRA | RIN, DC, 1'b1);
        bus.IR = 32'hE0000000;
        fetch("undef");
        step("undef T3", 26'd0, DC, 1'b1);
        bus.IR = 32'h10000000;
        fetch("st");
        step("st T3", GRB | BAO | RYI, 5'd3, 1'b1);
        step("st T4", RCO | RZLI, 5'd3, 1'b1);
        step("st T5", RZLO | MARI, 5'd3, 1'b1);
        step("st T6", GRA | ROUT | MDRI, DC, 1'b1);
        step("st T7", RAMW, DC, 1'b1);
        bus.IR = 32'h19A28000;
        fetch("addStop");
        step("addStop T3", GRB | ROUT | RYI, 5'd3, 1'b1);
        step("addStop T4", GRC | ROUT | RZLI, 5'd3, 1'b1);
        bus.stop = 1'b1;
        step("addStop T5", RZLO | GRA | RIN, 5'd3, 1'b1);
        step("stopHalt", 26'd0, DC, 1'b0);
        bus.stop = 1'b0;
        for (int i = 0; i < 5; i++) step("stopHalt hold", 26'd0, DC, 1'b0);
        pulseClear("stopHalt clear");
        bus.IR = 32'hD8000000;
        fetch("halt");
        step("halt T3", 26'd0, DC, 1'b1);
        for (int i = 0; i < 20; i++) step("halt hold", 26'd0, DC, 1'b0);
        pulseClear("halt clear");
        bus.IR = 32'h10000000;
        fetch("stAbort");
        step("stAbort T3", GRB | BAO | RYI, 5'd3, 1'b1);
        step("stAbort T4", RCO | RZLI, 5'd3, 1'b1);
        step("stAbort T5", RZLO | MARI, 5'd3, 1'b1);
        step("stAbort T6", GRA | ROUT | MDRI, DC, 1'b1);
        bus.IR = 32'hD0000000;
        pulseClear("stAbort clear");
        fetch("nop");
        step("nop T3", 26'd0, DC, 1'b1);
        fetch("nop2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
